fl_ckpt_ctrl: RTL and testbench
===============================

# fl_ckpt_ctrl

Branch-checkpoint controller for the physical-register Freelist. It snapshots the Freelist head pointer for each dispatched branch and tracks checkpoint age. On a mispredict it sequences a selective head-pointer restore, squashing the checkpoint and all younger ones. It sits beside the dispatch stage, between the branch unit's resolve bus and the Freelist's restore inputs.

## Interface
- PTR_W, 5, Freelist pointer width; matches `SYS_ROB_ADDR_WIDTH`.
- NUM_CKPT, 4, number of checkpoint entries.
- TAG_W, 2, checkpoint tag width; equals clog2(NUM_CKPT).
- DRAIN_CYC, 2, cycles allocation stays blocked after a restore.

Ports:
- Clock and reset: reset rst, synchronous, active-high; clock clk.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fl_head_ptr  in  PTR_W  current Freelist head.
- fl_dispatch_en_mask  in  3  PR allocations this cycle; slot 2 oldest.
- br_valid  in  1  a branch dispatches this cycle (at most one).
- br_slot  in  2  slot index of the branch (0..2).
- res_valid  in  1  branch resolve.
- res_tag  in  TAG_W  resolving checkpoint.
- res_mispredict  in  1  resolve is a mispredict.
- flush  in  1  full-pipeline recovery (exception/retire flush).
- ckpt_ready  out  1  a checkpoint is available and allocation is not blocked.
- ckpt_tag  out  TAG_W  tag granted to the current branch.
- fl_restore_en  out  1  one-cycle restore strobe to Freelist.
- fl_restore_ptr  out  PTR_W  head value to restore.
- squash_mask  out  NUM_CKPT  checkpoints squashed by the current restore.

## Operation
- Each entry holds: valid, ptr[PTR_W], older[NUM_CKPT] (the valid-vector captured at allocation, excluding itself).
- ckpt_tag is the lowest-index invalid entry. ckpt_ready = (any entry invalid) && state==IDLE.
- Allocation happens when br_valid && ckpt_ready. The snapshot ptr = fl_head_ptr + popcount(fl_dispatch_en_mask bits at slots ≥ br_slot), modulo 2^PTR_W. This includes the branch's own slot.
- br_valid while !ckpt_ready is ignored. Dispatch must stall on !ckpt_ready; the bench flags this as an error.
- A correct resolve (res_valid && !res_mispredict && valid[res_tag]) clears the entry and clears bit res_tag in every other entry's older vector.
- A mispredict (res_valid && res_mispredict && valid[res_tag]):
  - victim set = res_tag ∪ {j : older[j][res_tag]}.
  - Victim entries are cleared.
  - The FSM latches ptr[res_tag] and the victim set.
- A resolve to an invalid tag is ignored.
- FSM states:
  - IDLE: waits for a mispredict, then goes to RESTORE.
  - RESTORE: lasts one cycle; fl_restore_en=1 and fl_restore_ptr/squash_mask are driven. Next state is DRAIN with counter = DRAIN_CYC−1, or IDLE if DRAIN_CYC==0.
  - DRAIN: counts down to 0, then goes to IDLE.
- Priority: rst > flush > mispredict > correct resolve > allocation.
  - flush clears all entries and forces IDLE with outputs 0.
  - A mispredict in the same cycle as br_valid drops the allocation, since the branch is younger and squashed.
  - A mispredict of a still-valid tag during RESTORE/DRAIN re-enters RESTORE with the new pointer. Only older branches can still be valid.
  - A correct resolve and an allocation in the same cycle: the freed tag is not reusable until the next cycle.

## Timing
- Reset values: all entries invalid, state IDLE. ckpt_ready=1, ckpt_tag=0, fl_restore_en=0, fl_restore_ptr=0, squash_mask=0.
- ckpt_ready and ckpt_tag are combinational from registered state only; they do not depend on same-cycle br_valid or res_*.
- The entry is written at the posedge where allocation is sampled and is visible to resolves the next cycle.
- A mispredict sampled at edge N gives fl_restore_en high in cycle N+1 for exactly one cycle. ckpt_ready stays 0 from N+1 through N+1+DRAIN_CYC.
- All outputs are registered or derived from registers. There is no input-to-output combinational path except through ckpt_ready/ckpt_tag state.

## Configuration
- FL_CKPT_STATS_EN defined: adds output stat_mispred_cnt[15:0] and output stat_block_cnt[15:0].
  - stat_mispred_cnt counts accepted mispredicts.
  - stat_block_cnt counts cycles with br_valid && !ckpt_ready.
  - Both saturate at 16'hFFFF, are cleared by rst, and are unaffected by flush.
- FL_CKPT_STATS_EN undefined: those ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then idle: ckpt_ready=1, ckpt_tag=0, fl_restore_en=0.
- fl_head_ptr=30, mask=3'b111, br_slot=1 → entry 0 ptr=0 (30+2 wraps). A second branch next cycle gets ckpt_tag=1.
- Allocate tags 0,1,2,3 in order, then br_valid → ckpt_ready=0 and the branch is ignored. Correct-resolve tag 1 → next cycle ckpt_tag=1, ckpt_ready=1.
- Allocate 0(ptr 4), 1(ptr 7), 2(ptr 9), then mispredict tag 1 → one cycle later fl_restore_en=1, fl_restore_ptr=7, squash_mask=4'b0110. Tag 0 stays valid. ckpt_ready=0 for 1+DRAIN_CYC cycles.
- Mispredict tag 0 with br_valid in the same cycle → no new entry. In DRAIN, mispredict of the older valid tag → a second RESTORE with its ptr.
- flush during RESTORE → all entries invalid, IDLE next cycle, fl_restore_en=0. With FL_CKPT_STATS_EN, stat_mispred_cnt keeps its count.

Source files
------------

// File: rtl/fl_ckpt_ctrl.sv
// fl_ckpt_ctrl
// Branch-checkpoint controller for the physical-register Freelist.
// Snapshots the Freelist head for every dispatched branch, tracks relative
// checkpoint age through per-entry "older" vectors, and on a mispredict
// sequences a one-cycle head restore followed by an allocation drain window.
//
// Optional feature macro: FL_CKPT_STATS_EN (adds saturating statistics ports).
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   fl_head_ptr            current Freelist head
//   fl_dispatch_en_mask    PR allocations this cycle (slot 2 oldest)
//   br_valid, br_slot      branch dispatch and its slot
//   res_valid, res_tag,
//   res_mispredict         branch resolve bus
//   flush                  full-pipeline recovery
//   ckpt_ready, ckpt_tag   checkpoint availability and granted tag
//   fl_restore_en,
//   fl_restore_ptr         one-cycle restore strobe and head value
//   squash_mask            checkpoints squashed by the current restore
//   stat_mispred_cnt,
//   stat_block_cnt         (FL_CKPT_STATS_EN only) event counters
module fl_ckpt_ctrl #(
    parameter int PTR_W     = 5,
    parameter int NUM_CKPT  = 4,
    parameter int TAG_W     = 2,
    parameter int DRAIN_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PTR_W-1:0]    fl_head_ptr,
    input  logic [2:0]          fl_dispatch_en_mask,
    input  logic                br_valid,
    input  logic [1:0]          br_slot,
    input  logic                res_valid,
    input  logic [TAG_W-1:0]    res_tag,
    input  logic                res_mispredict,
    input  logic                flush,
    output logic                ckpt_ready,
    output logic [TAG_W-1:0]    ckpt_tag,
    output logic                fl_restore_en,
    output logic [PTR_W-1:0]    fl_restore_ptr,
    output logic [NUM_CKPT-1:0] squash_mask
`ifdef FL_CKPT_STATS_EN
    ,
    output logic [15:0]         stat_mispred_cnt,
    output logic [15:0]         stat_block_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESTORE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    // Number of PR allocations at or above the branch slot (the branch's own
    // slot and older slots have already consumed Freelist entries).
    function automatic logic [1:0] upper_slot_count(input logic [2:0] mask,
                                                    input logic [1:0] slot);
        logic [1:0] cnt;
        cnt = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (i >= int'(slot)) begin
                cnt = cnt + {1'b0, mask[i]};
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

    state_e                state_r, state_nxt_s;
    logic [CNT_W-1:0]      drain_cnt_r, drain_cnt_nxt_s;
    logic [NUM_CKPT-1:0]   valid_r, valid_nxt_s;
    logic [PTR_W-1:0]      ptr_r       [NUM_CKPT];
    logic [PTR_W-1:0]      ptr_nxt_s   [NUM_CKPT];
    logic [NUM_CKPT-1:0]   older_r     [NUM_CKPT];
    logic [NUM_CKPT-1:0]   older_nxt_s [NUM_CKPT];
    logic                  restore_en_r, restore_en_nxt_s;
    logic [PTR_W-1:0]      restore_ptr_r, restore_ptr_nxt_s;
    logic [NUM_CKPT-1:0]   squash_mask_r, squash_mask_nxt_s;

    logic                  any_free_s;
    logic [TAG_W-1:0]      free_tag_s;
    logic                  res_hit_s;
    logic                  mispred_s;
    logic                  good_res_s;
    logic                  alloc_s;
    logic [NUM_CKPT-1:0]   victim_s;
    logic [NUM_CKPT-1:0]   release_s;
    logic [PTR_W-1:0]      snap_ptr_s;

    // Lowest-index free entry, derived only from registered state.
    always_comb begin
        any_free_s = ~(&valid_r);
        free_tag_s = {TAG_W{1'b0}};
        for (int i = NUM_CKPT - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_tag_s = TAG_W'(i);
            end else begin
                free_tag_s = free_tag_s;
            end
        end
    end

    assign ckpt_ready = any_free_s && (state_r == ST_IDLE);
    assign ckpt_tag   = free_tag_s;

    // Event decode in priority order: flush > mispredict > correct resolve > allocation.
    always_comb begin
        res_hit_s  = res_valid && valid_r[res_tag];
        mispred_s  = !flush && res_hit_s && res_mispredict;
        good_res_s = !flush && res_hit_s && !res_mispredict;
        alloc_s    = !flush && !mispred_s && br_valid && ckpt_ready;
        snap_ptr_s = fl_head_ptr + PTR_W'(upper_slot_count(fl_dispatch_en_mask, br_slot));
        for (int j = 0; j < NUM_CKPT; j++) begin
            // Stale older bits of invalid entries must not leak into the squash set.
            victim_s[j]  = valid_r[j] && ((res_tag == TAG_W'(j)) || older_r[j][res_tag]);
            release_s[j] = good_res_s && (res_tag == TAG_W'(j));
        end
    end

    // Checkpoint table next-state.
    always_comb begin
        valid_nxt_s = valid_r;
        ptr_nxt_s   = ptr_r;
        older_nxt_s = older_r;
        if (flush) begin
            valid_nxt_s = {NUM_CKPT{1'b0}};
            for (int j = 0; j < NUM_CKPT; j++) begin
                older_nxt_s[j] = {NUM_CKPT{1'b0}};
            end
        end else if (mispred_s) begin
            valid_nxt_s = valid_r & ~victim_s;
            for (int j = 0; j < NUM_CKPT; j++) begin
                older_nxt_s[j] = older_r[j] & ~victim_s;
            end
        end else begin
            valid_nxt_s = valid_r & ~release_s;
            for (int j = 0; j < NUM_CKPT; j++) begin
                older_nxt_s[j] = older_r[j] & ~release_s;
            end
            if (alloc_s) begin
                valid_nxt_s[free_tag_s] = 1'b1;
                ptr_nxt_s[free_tag_s]   = snap_ptr_s;
                // A tag freed this same cycle is no longer older than the new branch.
                older_nxt_s[free_tag_s] = valid_r & ~release_s;
            end else begin
                valid_nxt_s = valid_nxt_s;
            end
        end
    end

    // Restore sequencer next-state and registered restore outputs.
    always_comb begin
        state_nxt_s       = state_r;
        drain_cnt_nxt_s   = drain_cnt_r;
        restore_en_nxt_s  = 1'b0;
        restore_ptr_nxt_s = {PTR_W{1'b0}};
        squash_mask_nxt_s = {NUM_CKPT{1'b0}};
        if (flush) begin
            state_nxt_s     = ST_IDLE;
            drain_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (mispred_s) begin
            state_nxt_s       = ST_RESTORE;
            restore_en_nxt_s  = 1'b1;
            restore_ptr_nxt_s = ptr_r[res_tag];
            squash_mask_nxt_s = victim_s;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_RESTORE: begin
                    if (DRAIN_CYC == 0) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s     = ST_DRAIN;
                        drain_cnt_nxt_s = CNT_W'(DRAIN_CYC - 1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == {CNT_W{1'b0}}) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        drain_cnt_nxt_s = drain_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_nxt_s     = ST_IDLE;
                    drain_cnt_nxt_s = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Checkpoint table registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {NUM_CKPT{1'b0}};
            for (int j = 0; j < NUM_CKPT; j++) begin
                ptr_r[j]   <= {PTR_W{1'b0}};
                older_r[j] <= {NUM_CKPT{1'b0}};
            end
        end else begin
            valid_r <= valid_nxt_s;
            ptr_r   <= ptr_nxt_s;
            older_r <= older_nxt_s;
        end
    end

    // Sequencer state and restore output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            drain_cnt_r   <= {CNT_W{1'b0}};
            restore_en_r  <= 1'b0;
            restore_ptr_r <= {PTR_W{1'b0}};
            squash_mask_r <= {NUM_CKPT{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            drain_cnt_r   <= drain_cnt_nxt_s;
            restore_en_r  <= restore_en_nxt_s;
            restore_ptr_r <= restore_ptr_nxt_s;
            squash_mask_r <= squash_mask_nxt_s;
        end
    end

    assign fl_restore_en  = restore_en_r;
    assign fl_restore_ptr = restore_ptr_r;
    assign squash_mask    = squash_mask_r;

`ifdef FL_CKPT_STATS_EN
    logic [15:0] stat_mispred_r;
    logic [15:0] stat_block_r;

    // Saturating statistics; flush deliberately leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_mispred_r <= 16'h0000;
            stat_block_r   <= 16'h0000;
        end else begin
            if (mispred_s && (stat_mispred_r != 16'hFFFF)) begin
                stat_mispred_r <= stat_mispred_r + 16'h0001;
            end else begin
                stat_mispred_r <= stat_mispred_r;
            end
            if (br_valid && !ckpt_ready && (stat_block_r != 16'hFFFF)) begin
                stat_block_r <= stat_block_r + 16'h0001;
            end else begin
                stat_block_r <= stat_block_r;
            end
        end
    end

    assign stat_mispred_cnt = stat_mispred_r;
    assign stat_block_cnt   = stat_block_r;
`endif

endmodule

// File: tb/tb_fl_ckpt_ctrl.sv
// Testbench for fl_ckpt_ctrl: directed vector table followed by random
// stimulus checked against an age-ordered reference model.
module tb_fl_ckpt_ctrl;

    localparam int DRAIN = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] fl_head_ptr;
    logic [2:0] fl_dispatch_en_mask;
    logic       br_valid;
    logic [1:0] br_slot;
    logic       res_valid;
    logic [1:0] res_tag;
    logic       res_mispredict;
    logic       flush;
    logic       ckpt_ready;
    logic [1:0] ckpt_tag;
    logic       fl_restore_en;
    logic [4:0] fl_restore_ptr;
    logic [3:0] squash_mask;
`ifdef FL_CKPT_STATS_EN
    logic [15:0] stat_mispred_cnt;
    logic [15:0] stat_block_cnt;
`endif

    fl_ckpt_ctrl #(.PTR_W(5), .NUM_CKPT(4), .TAG_W(2), .DRAIN_CYC(DRAIN)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .fl_head_ptr         (fl_head_ptr),
        .fl_dispatch_en_mask (fl_dispatch_en_mask),
        .br_valid            (br_valid),
        .br_slot             (br_slot),
        .res_valid           (res_valid),
        .res_tag             (res_tag),
        .res_mispredict      (res_mispredict),
        .flush               (flush),
        .ckpt_ready          (ckpt_ready),
        .ckpt_tag            (ckpt_tag),
        .fl_restore_en       (fl_restore_en),
        .fl_restore_ptr      (fl_restore_ptr),
        .squash_mask         (squash_mask)
`ifdef FL_CKPT_STATS_EN
        ,
        .stat_mispred_cnt    (stat_mispred_cnt),
        .stat_block_cnt      (stat_block_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: entries carry an allocation sequence number; a
    // mispredict squashes the tag and every valid entry allocated after it.
    bit         m_valid [4];
    int         m_ptr   [4];
    int         m_age   [4];
    int         m_seq;
    int         m_busy;
    bit         m_en;
    int         m_rptr;
    logic [3:0] m_rmask;
    int         m_mis;
    int         m_blk;

    function automatic int m_free_tag();
        for (int i = 0; i < 4; i++) begin
            if (!m_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit m_ready();
        return (m_free_tag() >= 0) && (m_busy == 0);
    endfunction

    task automatic model_step();
        bit pre_rdy;
        int ft;
        int a;
        int n;
        pre_rdy = m_ready();
        ft      = m_free_tag();
        if (br_valid && !pre_rdy) m_blk++;
        if (flush) begin
            for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
            m_busy = 0;
            m_en   = 1'b0;
        end else if (res_valid && res_mispredict && m_valid[res_tag]) begin
            m_mis++;
            a       = m_age[res_tag];
            m_rptr  = m_ptr[res_tag];
            m_rmask = 4'b0000;
            for (int j = 0; j < 4; j++) begin
                if (m_valid[j] && m_age[j] >= a) begin
                    m_rmask[j] = 1'b1;
                    m_valid[j] = 1'b0;
                end
            end
            m_en   = 1'b1;
            m_busy = 1 + DRAIN;
        end else begin
            m_en = 1'b0;
            if (m_busy > 0) m_busy--;
            if (res_valid && !res_mispredict && m_valid[res_tag]) m_valid[res_tag] = 1'b0;
            if (br_valid && pre_rdy) begin
                n = 0;
                for (int s = int'(br_slot); s < 3; s++) n += int'(fl_dispatch_en_mask[s]);
                m_valid[ft] = 1'b1;
                m_ptr[ft]   = (int'(fl_head_ptr) + n) % 32;
                m_age[ft]   = m_seq;
                m_seq++;
            end
        end
    endtask

    task automatic apply(input logic bv, input logic [1:0] slot, input logic [2:0] mask,
                         input logic [4:0] head, input logic rv, input logic [1:0] rtag,
                         input logic rmis, input logic fl);
        br_valid            = bv;
        br_slot             = slot;
        fl_dispatch_en_mask = mask;
        fl_head_ptr         = head;
        res_valid           = rv;
        res_tag             = rtag;
        res_mispredict      = rmis;
        flush               = fl;
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic       bv;
        logic [1:0] slot;
        logic [2:0] mask;
        logic [4:0] head;
        logic       rv;
        logic [1:0] rtag;
        logic       rmis;
        logic       fl;
        logic       e_rdy;
        logic       chk_tag;
        logic [1:0] e_tag;
        logic       e_en;
        logic [4:0] e_ptr;
        logic [3:0] e_mask;
    } vec_t;

    localparam int NV = 28;
    vec_t vt [NV];

    initial begin
        //        bv    slot   mask    head   rv    rtag  rmis  fl    rdy   ctag  tag   en    ptr    mask
        vt[0]  = '{1'b1, 2'd1, 3'b111, 5'd30, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 5'd0,  4'b0000};
        vt[1]  = '{1'b1, 2'd0, 3'b001, 5'd5,  1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 5'd0,  4'b0001};
        vt[2]  = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 5'd0,  4'b0000};
        vt[3]  = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 5'd0,  4'b0000};
        vt[4]  = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 5'd0,  4'b0000};
        vt[5]  = '{1'b1, 2'd2, 3'b100, 5'd4,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 5'd0,  4'b0000};
        vt[6]  = '{1'b1, 2'd0, 3'b000, 5'd10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 5'd0,  4'b0000};
        vt[7]  = '{1'b1, 2'd0, 3'b000, 5'd11, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 5'd0,  4'b0000};
        vt[8]  = '{1'b1, 2'd0, 3'b000, 5'd12, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  4'b0000};
        vt[9]  = '{1'b1, 2'd0, 3'b000, 5'd13, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  4'b0000};
        vt[10] = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 5'd0,  4'b0000};
        vt[11] = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 5'd0,  4'b0000};
        vt[12] = '{1'b1, 2'd0, 3'b000, 5'd4,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 5'd0,  4'b0000};
        vt[13] = '{1'b1, 2'd1, 3'b110, 5'd5,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 5'd0,  4'b0000};
        vt[14] = '{1'b1, 2'd0, 3'b001, 5'd8,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 5'd0,  4'b0000};
        vt[15] = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 5'd7,  4'b0110};
        vt[16] = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 5'd0,  4'b0000};
        vt[17] = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 5'd4,  4'b0001};
        vt[18] = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 5'd0,  4'b0000};
        vt[19] = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 5'd0,  4'b0000};
        vt[20] = '{1'b1, 2'd0, 3'b000, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 5'd0,  4'b0000};
        vt[21] = '{1'b1, 2'd2, 3'b011, 5'd3,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 5'd0,  4'b0000};
        vt[22] = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 5'd3,  4'b0010};
        vt[23] = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 5'd0,  4'b0000};
        vt[24] = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 5'd0,  4'b0000};
        vt[25] = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 5'd0,  4'b0000};
        vt[26] = '{1'b1, 2'd0, 3'b111, 5'd31, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 5'd0,  4'b0000};
        vt[27] = '{1'b0, 2'd0, 3'b000, 5'd0,  1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 5'd2,  4'b0001};

        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_ptr[i]   = 0;
            m_age[i]   = 0;
        end
        m_seq = 0; m_busy = 0; m_en = 1'b0; m_rptr = 0; m_rmask = 4'b0000;
        m_mis = 0; m_blk = 0;

        rst = 1'b1;
        br_valid = 1'b0; br_slot = 2'd0; fl_dispatch_en_mask = 3'b000; fl_head_ptr = 5'd0;
        res_valid = 1'b0; res_tag = 2'd0; res_mispredict = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_ready", 32'(ckpt_ready), 32'd1);
        chk("reset_tag", 32'(ckpt_tag), 32'd0);
        chk("reset_restore_en", 32'(fl_restore_en), 32'd0);
        chk("reset_restore_ptr", 32'(fl_restore_ptr), 32'd0);
        chk("reset_squash_mask", 32'(squash_mask), 32'd0);

        // Directed table: each row's expectations hold in the cycle after its edge.
        for (int v = 0; v < NV; v++) begin
            apply(vt[v].bv, vt[v].slot, vt[v].mask, vt[v].head,
                  vt[v].rv, vt[v].rtag, vt[v].rmis, vt[v].fl);
            chk($sformatf("vec%0d_ready", v), 32'(ckpt_ready), 32'(vt[v].e_rdy));
            if (vt[v].chk_tag) chk($sformatf("vec%0d_tag", v), 32'(ckpt_tag), 32'(vt[v].e_tag));
            chk($sformatf("vec%0d_restore_en", v), 32'(fl_restore_en), 32'(vt[v].e_en));
            if (vt[v].e_en) begin
                chk($sformatf("vec%0d_restore_ptr", v), 32'(fl_restore_ptr), 32'(vt[v].e_ptr));
                chk($sformatf("vec%0d_squash_mask", v), 32'(squash_mask), 32'(vt[v].e_mask));
            end
        end

        // Random phase against the reference model; dispatch honours ckpt_ready.
        for (int c = 0; c < 4000; c++) begin
            logic bv;
            bv = m_ready() && ($urandom_range(0, 1) == 1);
            apply(bv, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 99) < 30), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) < 2));
            chk("rand_ready", 32'(ckpt_ready), 32'(m_ready()));
            if (m_free_tag() >= 0) chk("rand_tag", 32'(ckpt_tag), 32'(m_free_tag()));
            chk("rand_restore_en", 32'(fl_restore_en), 32'(m_en));
            if (m_en) begin
                chk("rand_restore_ptr", 32'(fl_restore_ptr), 32'(m_rptr));
                chk("rand_squash_mask", 32'(squash_mask), 32'(m_rmask));
            end
        end

`ifdef FL_CKPT_STATS_EN
        chk("stat_mispred_cnt", 32'(stat_mispred_cnt), 32'(m_mis));
        chk("stat_block_cnt", 32'(stat_block_cnt), 32'(m_blk));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
